// File: rtl/cpu_stage_sequencer_pkg.sv
// Shared phase encoding and width constants for the CPU stage sequencer.
package cpu_stage_sequencer_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_GETREGS,
    ST_READMEM,
    ST_WRITEBACK
  } state_t;

  localparam int INT_LINES_DEF = 8;
  localparam int ID_W          = 8;
endpackage

// File: rtl/cpu_stage_sequencer_if.sv
// Memory handshake, interrupt lines and control-unit/PC outputs of the sequencer.
interface cpu_stage_sequencer_if
  import cpu_stage_sequencer_pkg::*;
#(
  parameter int INT_LINES = INT_LINES_DEF,
  parameter int CNT_W     = 32
);
  logic                 start;
  logic                 busy;
  logic                 reti;
  logic [INT_LINES-1:0] int_req;
  logic                 fetch;
  logic                 getRegs;
  logic                 readMem;
  logic                 writeBack;
  logic                 take_int;
  logic [ID_W-1:0]      int_id;
  logic                 in_isr;
  logic [CNT_W-1:0]     instr_count;

  modport master (
    input  start, busy, reti, int_req,
    output fetch, getRegs, readMem, writeBack, take_int, int_id, in_isr, instr_count
  );

  modport slave (
    output start, busy, reti, int_req,
    input  fetch, getRegs, readMem, writeBack, take_int, int_id, in_isr, instr_count
  );
endinterface

// File: rtl/cpu_stage_sequencer_int_priority_encoder.sv
// Finds the lowest-numbered pending interrupt; bit 0 has the highest priority.
module int_priority_encoder
  import cpu_stage_sequencer_pkg::*;
#(
  parameter int INT_LINES = INT_LINES_DEF
) (
  input  logic [INT_LINES-1:0] i_pending,
  output logic                 o_any,
  output logic [ID_W-1:0]      o_idx
);
  always_comb begin
    o_any = |i_pending;
    o_idx = '0;
    for (int i = INT_LINES - 1; i >= 0; i--) begin
      if (i_pending[i]) o_idx = ID_W'(i);
    end
  end
endmodule

// File: rtl/cpu_stage_sequencer.sv
// Steps fetch/getRegs/readMem/writeBack, stretching memory phases and taking interrupts at writeback exit.
module cpu_stage_sequencer
  import cpu_stage_sequencer_pkg::*;
#(
  parameter int INT_LINES = INT_LINES_DEF,
  parameter int CNT_W     = 32
) (
  input logic                   clk,
  input logic                   reset,
  cpu_stage_sequencer_if.master bus
);
  state_t               r_state, w_state_next;
  logic                 r_issued, w_issued_next;
  logic [INT_LINES-1:0] r_pending, r_int_prev, w_edge, w_clear;
  logic                 r_in_isr;
  logic [ID_W-1:0]      r_int_id;
  logic [CNT_W-1:0]     r_count;
  logic                 r_fetch, r_getRegs, r_readMem, r_writeBack;
  logic                 w_advance, w_wb_exit, w_take, w_any;
  logic [ID_W-1:0]      w_idx;

  int_priority_encoder #(.INT_LINES(INT_LINES)) u_enc (
    .i_pending (r_pending),
    .o_any     (w_any),
    .o_idx     (w_idx)
  );

  // start only matters before the access is issued; afterwards busy alone ends the phase
  always_comb begin
    w_advance     = r_issued ? !bus.busy : !bus.start;
    w_wb_exit     = (r_state == ST_WRITEBACK) && w_advance;
    w_take        = w_wb_exit && !bus.reti && !r_in_isr && w_any;
    w_edge        = bus.int_req & ~r_int_prev;
    w_clear       = w_take ? (INT_LINES'(1) << w_idx) : '0;
    w_issued_next = r_issued;
    if (r_state == ST_IDLE || w_advance) w_issued_next = 1'b0;
    else if (!r_issued && bus.start)     w_issued_next = 1'b1;
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:      w_state_next = ST_FETCH;
      ST_FETCH:     if (w_advance) w_state_next = ST_GETREGS;
      ST_GETREGS:   if (w_advance) w_state_next = ST_READMEM;
      ST_READMEM:   if (w_advance) w_state_next = ST_WRITEBACK;
      ST_WRITEBACK: if (w_advance) w_state_next = ST_FETCH;
      default:      w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_issued    <= 1'b0;
      r_fetch     <= 1'b0;
      r_getRegs   <= 1'b0;
      r_readMem   <= 1'b0;
      r_writeBack <= 1'b0;
      r_int_prev  <= '0;
      r_pending   <= '0;
      r_in_isr    <= 1'b0;
      r_int_id    <= '0;
      r_count     <= '0;
    end else begin
      r_state     <= w_state_next;
      r_issued    <= w_issued_next;
      r_fetch     <= (w_state_next == ST_FETCH);
      r_getRegs   <= (w_state_next == ST_GETREGS);
      r_readMem   <= (w_state_next == ST_READMEM);
      r_writeBack <= (w_state_next == ST_WRITEBACK);
      r_int_prev  <= bus.int_req;
      r_pending   <= (r_pending & ~w_clear) | w_edge;
      if (w_wb_exit) r_count <= r_count + CNT_W'(1);
      if (w_wb_exit && bus.reti) r_in_isr <= 1'b0;
      else if (w_take)           r_in_isr <= 1'b1;
      if (w_take) r_int_id <= w_idx;
    end
  end

  assign bus.fetch       = r_fetch;
  assign bus.getRegs     = r_getRegs;
  assign bus.readMem     = r_readMem;
  assign bus.writeBack   = r_writeBack;
  assign bus.take_int    = w_take;
  assign bus.int_id      = w_take ? w_idx : r_int_id;
  assign bus.in_isr      = r_in_isr;
  assign bus.instr_count = r_count;
endmodule
